// File: rtl/mono_expand_arbiter_if.sv
// Requester/response bundle for the shared monomial expander.
// The master side is the requesters plus the downstream consumer.
interface mono_expand_arbiter_if #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_nibble;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [14:0]       rsp_mono;
  logic [15:0]       xfer_cnt;

  modport master (
    output req_valid, req_nibble, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_mono, xfer_cnt
  );
  modport slave (
    input  req_valid, req_nibble, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_mono, xfer_cnt
  );
endinterface

// File: rtl/mono_expand_arbiter.sv
// Round-robin share of one 4-input monomial expander among NREQ requesters,
// with a 2-entry in-order response FIFO and a wrapping transfer counter.
module mono_expand (
  input  logic [3:0]  nibble,
  output logic [14:0] mono
);
  logic a, b, c, d;
  assign {a, b, c, d} = nibble;
  assign mono = {a&b&c&d,
                 b&c&d, a&c&d, a&b&d, a&b&c,
                 c&d, b&d, b&c, a&d, a&c, a&b,
                 d, c, b, a};
endmodule

module mono_expand_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input logic clk,
  input logic rst_n,
  mono_expand_arbiter_if.slave bus
);
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [14:0]    mono;
  } rsp_t;

  rsp_t            fifo_q [2];
  logic            rd_ptr, wr_ptr;
  logic [1:0]      count;
  logic [IDW-1:0]  rr_ptr;
  logic [15:0]     xfer_q;

  logic            can_accept, gnt_found, push, pop;
  logic [IDW-1:0]  gnt_idx, rr_next;
  logic [NREQ-1:0] req_ready;
  logic [3:0]      sel_nibble;
  logic [14:0]     push_mono;
  int              j;

  // Acceptance depends only on registered occupancy, never on rsp_ready.
  assign can_accept = (count != 2'd2);

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    req_ready = '0;
    j         = 0;
    if (can_accept) begin
      for (int k = 0; k < NREQ; k++) begin
        j = int'(rr_ptr) + k;
        if (j >= NREQ) j = j - NREQ;
        if (!gnt_found && bus.req_valid[j]) begin
          gnt_found = 1'b1;
          gnt_idx   = j[IDW-1:0];
        end
      end
    end
    if (gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign push       = gnt_found;
  assign pop        = (count != 2'd0) && bus.rsp_ready;
  assign sel_nibble = bus.req_nibble[{gnt_idx, 2'b00} +: 4];
  assign rr_next    = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);

  mono_expand u_expand (.nibble(sel_nibble), .mono(push_mono));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      rr_ptr    <= '0;
      xfer_q    <= 16'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{id: gnt_idx, mono: push_mono};
        wr_ptr         <= ~wr_ptr;
        rr_ptr         <= rr_next;
        xfer_q         <= xfer_q + 16'd1;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (count != 2'd0);
  assign bus.rsp_id    = fifo_q[rd_ptr].id;
  assign bus.rsp_mono  = fifo_q[rd_ptr].mono;
  assign bus.xfer_cnt  = xfer_q;
endmodule

// File: tb/tb_mono_expand_arbiter.sv
// Directed bench for mono_expand_arbiter with NREQ=4.
module tb_mono_expand_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mono_expand_arbiter_if #(.NREQ(4)) bus ();
  mono_expand_arbiter #(.NREQ(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  nibs  [3];
  logic [14:0] monos [3];
  int e;

  initial begin
    nibs  = '{4'h0, 4'h8, 4'hF};
    monos = '{15'h0000, 15'h0001, 15'h7FFF};
    rst_n = 1'b0;
    bus.req_valid  = '0;
    bus.req_nibble = '0;
    bus.rsp_ready  = 1'b0;
    #3;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    0);
    chk("rst_rsp_mono",  32'(bus.rsp_mono),  0);
    chk("rst_xfer_cnt",  32'(bus.xfer_cnt),  0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    @(negedge clk) rst_n = 1'b1;

    // single request from requester 2, nibble 1011
    bus.req_valid  = 4'b0100;
    bus.req_nibble = 16'h0B00;
    bus.rsp_ready  = 1'b1;
    #1 chk("single_gnt", 32'(bus.req_ready), 32'b0100);
    tick();
    chk("single_valid", 32'(bus.rsp_valid), 1);
    chk("single_id",    32'(bus.rsp_id),    2);
    chk("single_mono",  32'(bus.rsp_mono),  32'h126D);
    chk("single_xfer",  32'(bus.xfer_cnt),  1);
    bus.req_valid = '0;
    #1 chk("single_gnt_drop", 32'(bus.req_ready), 0);
    tick();
    chk("single_popped", 32'(bus.rsp_valid), 0);

    // expander corners from requester 0
    for (int i = 0; i < 3; i++) begin
      bus.req_valid  = 4'b0001;
      bus.req_nibble = {12'h000, nibs[i]};
      tick();
      chk("corner_id",   32'(bus.rsp_id),   0);
      chk("corner_mono", 32'(bus.rsp_mono), 32'(monos[i]));
    end
    bus.req_valid = '0;
    tick();
    chk("corner_drain", 32'(bus.rsp_valid), 0);
    chk("corner_xfer",  32'(bus.xfer_cnt),  4);

    // round robin: pointer sits at 1 after the last grant to 0
    bus.req_valid  = 4'hF;
    bus.req_nibble = 16'h8421;
    for (int k = 0; k < 8; k++) begin
      e = (1 + k) % 4;
      #1 chk("rr_gnt", 32'(bus.req_ready), 32'(1 << e));
      tick();
      chk("rr_id",   32'(bus.rsp_id),   32'(e));
      chk("rr_mono", 32'(bus.rsp_mono), 32'(1 << (3 - e)));
    end
    bus.req_valid = '0;
    tick();
    chk("rr_drain", 32'(bus.rsp_valid), 0);
    chk("rr_xfer",  32'(bus.xfer_cnt),  12);

    // backpressure until full
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1010;
    #1 chk("bp_gnt1", 32'(bus.req_ready), 32'b0010);
    tick();
    chk("bp_valid1", 32'(bus.rsp_valid), 1);
    chk("bp_id1",    32'(bus.rsp_id),    1);
    chk("bp_gnt3",   32'(bus.req_ready), 32'b1000);
    tick();
    chk("bp_full_gnt", 32'(bus.req_ready), 0);
    chk("bp_full_id",  32'(bus.rsp_id),    1);
    chk("bp_full_xfer",32'(bus.xfer_cnt),  14);
    tick();
    chk("bp_stable_valid", 32'(bus.rsp_valid), 1);
    chk("bp_stable_id",    32'(bus.rsp_id),    1);
    chk("bp_stable_gnt",   32'(bus.req_ready), 0);
    bus.rsp_ready = 1'b1;
    #1 chk("bp_ready_no_gnt", 32'(bus.req_ready), 0);
    tick();
    chk("bp_pop1_id",  32'(bus.rsp_id),    3);
    chk("bp_resume",   32'(bus.req_ready), 32'b0010);
    tick();
    chk("bp_pop3_id",  32'(bus.rsp_id),    1);
    chk("bp_xfer15",   32'(bus.xfer_cnt),  15);
    bus.rsp_ready = 1'b0;
    tick();
    chk("refill_xfer", 32'(bus.xfer_cnt),  16);
    chk("refill_id",   32'(bus.rsp_id),    1);
    chk("refill_gnt",  32'(bus.req_ready), 0);

    // reset with two entries queued
    bus.req_valid = 4'b1100;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 0);
    chk("mid_rst_mono",  32'(bus.rsp_mono),  0);
    chk("mid_rst_id",    32'(bus.rsp_id),    0);
    chk("mid_rst_xfer",  32'(bus.xfer_cnt),  0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("post_rst_gnt", 32'(bus.req_ready), 32'b0100);
    bus.rsp_ready = 1'b1;
    tick();
    chk("post_rst_id",   32'(bus.rsp_id),   2);
    chk("post_rst_xfer", 32'(bus.xfer_cnt), 1);

    // counter wrap; requester 1 expands F, requester 2 expands 0
    bus.req_valid  = 4'hF;
    bus.req_nibble = 16'h00F0;
    repeat (65534) @(posedge clk);
    #1;
    chk("wrap_pre_xfer", 32'(bus.xfer_cnt), 32'hFFFF);
    chk("wrap_pre_id",   32'(bus.rsp_id),   0);
    tick();
    chk("wrap_xfer0", 32'(bus.xfer_cnt), 0);
    chk("wrap_id",    32'(bus.rsp_id),   1);
    chk("wrap_mono",  32'(bus.rsp_mono), 32'h7FFF);
    chk("wrap_valid", 32'(bus.rsp_valid), 1);
    tick();
    chk("wrap_xfer1", 32'(bus.xfer_cnt), 1);
    chk("wrap_id2",   32'(bus.rsp_id),   2);
    chk("wrap_mono2", 32'(bus.rsp_mono), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mono_expand_arbiter.md
Name: mono_expand_arbiter

Overview:
- Shares one 4-input monomial expander (h_i, 15 monomials of nibble {a,b,c,d}) among NREQ nibble requesters in the two-stage S-box datapath.
- Round-robin arbitration selects one request per cycle. The selected nibble is expanded, tagged with the requester index and pushed into a 2-entry response FIFO with valid/ready backpressure.
- A wrapping transfer counter gives a debug and performance view.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- IDW, $clog2(NREQ), requester-index width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_nibble  in  4*NREQ  per-requester nibble; requester i uses bits [4i+3:4i], bit 3 = a, bit 0 = d
- req_ready  out  NREQ  per-requester grant/accept, one-hot or zero
- rsp_valid  out  1  response FIFO head valid
- rsp_ready  in  1  downstream accepts the head
- rsp_id  out  IDW  requester index of the head entry
- rsp_mono  out  15  monomial vector of the head entry, h_i bit ordering: [3:0]=a,b,c,d; [9:4]=ab,ac,ad,bc,bd,cd; [13:10]=abc,abd,acd,bcd; [14]=abcd
- xfer_cnt  out  16  count of accepted requests, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_id=0, rsp_mono=0, xfer_cnt=0.
  - Round-robin pointer=0, FIFO count=0, FIFO storage cleared.
- can_accept = (fifo_count < 2). The value is registered-state only; rsp_ready does not feed req_ready.
- Arbitration, every cycle while can_accept:
  - Search req_valid starting at the pointer, ascending with wrap.
  - The first asserted index i gets req_ready[i]=1; all other req_ready bits are 0.
  - req_ready depends combinationally on req_valid and state.
- If !can_accept or no req_valid is asserted, req_ready=0.
- Transfer occurs when req_valid[i] && req_ready[i]. On the same edge:
  - Push {i, h_i(nibble_i)} into the FIFO tail.
  - Pointer <= (i+1) mod NREQ.
  - xfer_cnt increments.
- The pointer is unchanged on cycles with no transfer.
- Expander is combinational. Response latency is 1 cycle: a request accepted at edge t appears at the FIFO head (rsp_valid=1) after edge t when the FIFO was empty.
- Pop occurs on rsp_valid && rsp_ready.
- Simultaneous push and pop:
  - count=1: count stays 1. The pushed entry becomes the head next cycle and order is preserved.
  - count=2: push cannot occur because can_accept=0.
- Backpressure: rsp_valid, rsp_id and rsp_mono stay stable while rsp_valid && !rsp_ready.
- FIFO is strict in-order. No entry is dropped or duplicated.
- Throughput: with rsp_ready held high, one transfer per cycle is sustained (count oscillates 0->1->1...).
- Full: with rsp_ready low, exactly 2 transfers are accepted. req_ready then stays 0 until a pop.
- Requester rules:
  - A requester may drop req_valid without a transfer; no state is affected.
  - The nibble is sampled only on the transfer edge.
- Reset mid-operation: FIFO contents are discarded and all outputs return to reset values immediately. There are no pending grants after release.
- NREQ not a power of two: pointer wrap uses mod NREQ. IDs >= NREQ never appear.

Test Plan:
- Single request: NREQ=4, requester 2 presents 4'b1011 with rsp_ready=1 -> req_ready=4'b0100 for one cycle; next cycle rsp_valid=1, rsp_id=2, rsp_mono=15'h126D; xfer_cnt=1.
- Expander corners, one request per cycle from requester 0:
  - 4'h0 -> rsp_mono=15'h0000.
  - 4'h8 -> 15'h0001.
  - 4'hF -> 15'h7FFF.
- Round-robin fairness: all four req_valid high continuously with rsp_ready=1 -> grant order 0,1,2,3,0,1,...; rsp_id follows the same sequence; each requester gets 1 grant per 4 cycles.
- Backpressure and full:
  - rsp_ready=0 with requesters 1 and 3 valid -> two transfers (ids 1 then 3), then req_ready=0 and rsp_valid stays 1 with rsp_id=1 stable.
  - Raise rsp_ready -> pops 1, then 3, in order; acceptance resumes the cycle after count drops below 2.
- Reset mid-stream: assert rst_n=0 with count=2 -> rsp_valid=0, rsp_mono=0, xfer_cnt=0 immediately; after release the first grant goes to the lowest valid index from pointer 0.
- Counter wrap: force 65536 transfers -> xfer_cnt returns to 0 with no effect on the datapath.
